score_keeper: RTL and testbench

//  Downstream consumer of the per-lane note blocks. Collects one-cycle hit

---
 rtl/score_keeper.sv | 273 +++++++++++++++++++++++++++
 tb/tb_score_keeper.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
`timescale 1ns/1ps
// score_keeper: collects per-lane hit/miss pulses and keeps score, combo streak and
// multiplier. The binary score is converted to packed BCD by an iterative double-dabble
// converter. Optional feature: define SCORE_HIGH_EN to keep a best-score register
// that is shown on high_bcd; when it is undefined, high_bcd is tied to 0.
//
// Handshake note: hit_pulse/miss_pulse are fire-and-forget one-cycle pulses with no
// ready. Each pulse is latched into a per-lane pending bit and serviced later.
// bcd_busy is a status level, not a handshake; score_bcd holds its value until a
// conversion completes.
module score_keeper #(
    parameter int NUM_LANES   = 4,
    parameter int SCORE_W     = 14,
    parameter int BASE_POINTS = 10,
    parameter int COMBO_STEP  = 8,
    parameter int MAX_MULT    = 4
) (
    input  logic                 clk,
    input  logic                 resetbtn_n,
    input  logic                 game_start,
    input  logic                 game_active,
    input  logic [NUM_LANES-1:0] hit_pulse,
    input  logic [NUM_LANES-1:0] miss_pulse,
    output logic [15:0]          score_bcd,
    output logic [7:0]           combo,
    output logic [2:0]           multiplier,
    output logic                 bcd_busy,
    output logic [15:0]          high_bcd,
    output logic                 dbg_state_o,
    output logic                 dbg_cv_state_o
);

    localparam int                SW1         = SCORE_W + 1;
    localparam int                CNT_W       = $clog2(SCORE_W + 1);
    localparam logic [SW1-1:0]    SCORE_MAX   = SW1'(9999);
    localparam logic [SCORE_W-1:0] SCORE_MAX_S = SCORE_W'(9999);
    localparam logic [SW1-1:0]    BASE_C      = SW1'(BASE_POINTS);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(SCORE_W - 1);
    localparam logic [7:0]        STEP_C      = 8'(COMBO_STEP);
    localparam logic [7:0]        MSTEP_CAP   = 8'(MAX_MULT - 1);
    localparam logic [2:0]        MULT_MAX    = 3'(MAX_MULT);

    typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_e;
    typedef enum logic {CV_IDLE = 1'b0, CV_SHIFT = 1'b1} cv_e;

    // Round control.
    state_e               state_q, state_d;
    logic                 clear_round, leave_play, run;

    // Pending events and the service pick.
    logic [NUM_LANES-1:0] pend_hit_q, pend_hit_d, pend_miss_q, pend_miss_d;
    logic [NUM_LANES-1:0] pend_any, svc_mask;
    logic                 svc_miss;

    // Score state.
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [7:0]           combo_q, combo_d, combo_inc, mstep;
    logic [2:0]           mult_q, mult_d, mult_new;
    logic [SW1-1:0]       sum;

    // BCD converter.
    cv_e                  cv_q, cv_d;
    logic [SCORE_W-1:0]   shift_q, shift_d;
    logic [15:0]          acc_q, acc_d, cv_adj, cv_step;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 src_q, src_d;          // 0: score, 1: high score
    logic                 score_pend_q, score_pend_d;
    logic [15:0]          score_bcd_q, score_bcd_d;
    logic                 cv_done, load_score, load_high;
    logic                 high_pend_w;
    logic [SCORE_W-1:0]   high_val_w;

    // Add 3 to every BCD digit that is 5 or more, before the next shift.
    function automatic logic [15:0] dd_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Round FSM: game_start (re)starts a round, and dropping game_active ends it.
    always_comb begin
        state_d     = state_q;
        clear_round = 1'b0;
        leave_play  = 1'b0;
        run         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (game_start) begin
                    state_d     = S_PLAY;
                    clear_round = 1'b1;
                end
            end
            S_PLAY: begin
                if (game_start) begin
                    clear_round = 1'b1;
                end else if (!game_active) begin
                    state_d    = S_IDLE;
                    leave_play = 1'b1;
                end else begin
                    run = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lowest lane with any pending event is serviced; a miss on that lane wins.
    assign pend_any = pend_hit_q | pend_miss_q;
    assign svc_mask = pend_any & (~pend_any + NUM_LANES'(1));
    assign svc_miss = |(pend_miss_q & svc_mask);

    // Hit arithmetic uses the multiplier value from before this hit.
    assign sum       = {1'b0, score_q} + BASE_C * SW1'(mult_q);
    assign combo_inc = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
    assign mstep     = combo_inc / STEP_C;
    assign mult_new  = (mstep >= MSTEP_CAP) ? MULT_MAX : 3'(mstep + 8'd1);

    // Score, combo, multiplier and pending-event next state.
    always_comb begin
        score_d     = score_q;
        combo_d     = combo_q;
        mult_d      = mult_q;
        pend_hit_d  = pend_hit_q;
        pend_miss_d = pend_miss_q;
        if (clear_round) begin
            score_d     = '0;
            combo_d     = '0;
            mult_d      = 3'd1;
            pend_hit_d  = '0;
            pend_miss_d = '0;
        end else if (run) begin
            if (|pend_any) begin
                if (svc_miss) begin
                    combo_d = '0;
                    mult_d  = 3'd1;
                end else begin
                    score_d = (sum > SCORE_MAX) ? SCORE_MAX_S : sum[SCORE_W-1:0];
                    combo_d = combo_inc;
                    mult_d  = mult_new;
                end
            end
            // A new pulse on the serviced lane is kept: set beats clear.
            pend_hit_d  = (pend_hit_q & ~svc_mask) | hit_pulse;
            pend_miss_d = (pend_miss_q & ~svc_mask) | miss_pulse;
        end else begin
            pend_hit_d  = '0;
            pend_miss_d = '0;
        end
    end

    // One double-dabble step per busy cycle.
    assign cv_adj  = dd_adjust(acc_q);
    assign cv_step = {cv_adj[14:0], shift_q[SCORE_W-1]};
    assign cv_done = (cv_q == CV_SHIFT) && (cnt_q == CNT_LAST);

    // Converter FSM. The score has priority over the high score. A score change
    // during a score conversion discards that result and restarts immediately.
    always_comb begin
        cv_d       = cv_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        load_score = 1'b0;
        load_high  = 1'b0;
        case (cv_q)
            CV_IDLE: begin
                if (score_pend_q)     load_score = 1'b1;
                else if (high_pend_w) load_high  = 1'b1;
            end
            CV_SHIFT: begin
                acc_d   = cv_step;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cv_done) begin
                    cv_d = CV_IDLE;
                    if (!src_q && score_pend_q) load_score = 1'b1;
                end
            end
            default: cv_d = CV_IDLE;
        endcase
        if (load_score) begin
            cv_d    = CV_SHIFT;
            shift_d = score_q;
            acc_d   = '0;
            cnt_d   = '0;
            src_d   = 1'b0;
        end else if (load_high) begin
            cv_d    = CV_SHIFT;
            shift_d = high_val_w;
            acc_d   = '0;
            cnt_d   = '0;
            src_d   = 1'b1;
        end
    end

    assign score_pend_d = (score_d != score_q) | (score_pend_q & ~load_score);
    assign score_bcd_d  = (cv_done && !src_q && !score_pend_q) ? cv_step : score_bcd_q;

    // State registers for the round, the score and the converter.
    always_ff @(posedge clk or negedge resetbtn_n) begin
        if (!resetbtn_n) begin
            state_q      <= S_IDLE;
            pend_hit_q   <= '0;
            pend_miss_q  <= '0;
            score_q      <= '0;
            combo_q      <= '0;
            mult_q       <= 3'd1;
            cv_q         <= CV_IDLE;
            shift_q      <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            src_q        <= 1'b0;
            score_pend_q <= 1'b0;
            score_bcd_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_hit_q   <= pend_hit_d;
            pend_miss_q  <= pend_miss_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            mult_q       <= mult_d;
            cv_q         <= cv_d;
            shift_q      <= shift_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            src_q        <= src_d;
            score_pend_q <= score_pend_d;
            score_bcd_q  <= score_bcd_d;
        end
    end

`ifdef SCORE_HIGH_EN
    logic [SCORE_W-1:0] high_q;
    logic               high_pend_q, high_pend_d, high_up;
    logic [15:0]        high_bcd_q;

    assign high_up     = leave_play && (score_q > high_q);
    assign high_pend_d = high_up | (high_pend_q & ~load_high);

    // Best score is captured when a round ends and is cleared only by reset.
    always_ff @(posedge clk or negedge resetbtn_n) begin
        if (!resetbtn_n) begin
            high_q      <= '0;
            high_pend_q <= 1'b0;
            high_bcd_q  <= '0;
        end else begin
            if (high_up) high_q <= score_q;
            high_pend_q <= high_pend_d;
            if (cv_done && src_q && !high_pend_q) high_bcd_q <= cv_step;
        end
    end

    assign high_pend_w = high_pend_q;
    assign high_val_w  = high_q;
    assign high_bcd    = high_bcd_q;
`else
    assign high_pend_w = 1'b0;
    assign high_val_w  = '0;
    assign high_bcd    = 16'h0000;
`endif

    assign score_bcd      = score_bcd_q;
    assign combo          = combo_q;
    assign multiplier     = mult_q;
    assign bcd_busy       = (cv_q == CV_SHIFT);
    assign dbg_state_o    = state_q;
    assign dbg_cv_state_o = cv_q;

endmodule

// File: tb/tb_score_keeper.sv
`timescale 1ns/1ps
// Bench for score_keeper: reset values, a hand-computed vector table, targeted
// multi-cycle sequences and a randomized phase checked against a behavioural model.
module tb_score_keeper;
    localparam int NUM_LANES = 4;

    logic        clk, resetbtn_n, game_start, game_active;
    logic [3:0]  hit_pulse, miss_pulse;
    logic [15:0] score_bcd, high_bcd;
    logic [7:0]  combo;
    logic [2:0]  multiplier;
    logic        bcd_busy, dbg_state_o, dbg_cv_state_o;

    score_keeper #(
        .NUM_LANES(4), .SCORE_W(14), .BASE_POINTS(10), .COMBO_STEP(8), .MAX_MULT(4)
    ) dut (
        .clk(clk), .resetbtn_n(resetbtn_n), .game_start(game_start),
        .game_active(game_active), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .score_bcd(score_bcd), .combo(combo), .multiplier(multiplier),
        .bcd_busy(bcd_busy), .high_bcd(high_bcd),
        .dbg_state_o(dbg_state_o), .dbg_cv_state_o(dbg_cv_state_o)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference model.
    int m_score, m_combo, m_mult, m_high;
    bit m_play;
    bit m_ph[NUM_LANES];
    bit m_pm[NUM_LANES];

    function automatic logic [31:0] to_bcd(input int v);
        return 32'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    function automatic int bcd_to_int(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic model_clear_pend();
        for (int i = 0; i < NUM_LANES; i++) begin
            m_ph[i] = 1'b0;
            m_pm[i] = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_combo = 0; m_mult = 1; m_high = 0; m_play = 1'b0;
        model_clear_pend();
    endtask

    // Applies the round rules for one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int lane;
        lane = -1;
        if (game_start) begin
            m_play = 1'b1; m_score = 0; m_combo = 0; m_mult = 1;
            model_clear_pend();
        end else if (m_play && !game_active) begin
            m_play = 1'b0;
            if (m_score > m_high) m_high = m_score;
            model_clear_pend();
        end else if (m_play) begin
            for (int i = 0; i < NUM_LANES; i++)
                if (lane < 0 && (m_ph[i] || m_pm[i])) lane = i;
            if (lane >= 0) begin
                if (m_pm[lane]) begin
                    m_combo = 0;
                    m_mult  = 1;
                end else begin
                    m_score = m_score + 10 * m_mult;
                    if (m_score > 9999) m_score = 9999;
                    if (m_combo < 255) m_combo = m_combo + 1;
                    m_mult = 1 + m_combo / 8;
                    if (m_mult > 4) m_mult = 4;
                end
                m_ph[lane] = 1'b0;
                m_pm[lane] = 1'b0;
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (hit_pulse[i])  m_ph[i] = 1'b1;
                if (miss_pulse[i]) m_pm[i] = 1'b1;
            end
        end
    endtask

    // Driver tasks.
    task automatic drive(input bit s, input bit a, input logic [3:0] h, input logic [3:0] m);
        game_start  = s;
        game_active = a;
        hit_pulse   = h;
        miss_pulse  = m;
    endtask

    task automatic edge_only();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic tick();
        edge_only();
        check("combo", 32'(combo), 32'(m_combo));
        check("mult", 32'(multiplier), 32'(m_mult));
        check("state", 32'(dbg_state_o), 32'(m_play));
    endtask

    task automatic idle_ticks(input int n);
        game_start = 1'b0; hit_pulse = '0; miss_pulse = '0;
        repeat (n) tick();
    endtask

    task automatic settle_check();
        idle_ticks(40);
        check("score_bcd", 32'(score_bcd), to_bcd(m_score));
        check("bcd_busy_idle", 32'(bcd_busy), 32'd0);
`ifdef SCORE_HIGH_EN
        check("high_bcd", 32'(high_bcd), to_bcd(m_high));
`else
        check("high_bcd_tied", 32'(high_bcd), 32'd0);
`endif
    endtask

    typedef struct {
        bit         start;
        bit         act;
        logic [3:0] hit;
        logic [3:0] miss;
        int         exp_combo;
        int         exp_mult;
    } vec_t;
    vec_t tbl[20];

    int  lat, prev_val, off_cnt;
    bit  seen, mono_ok;
    logic [3:0] rh, rm;

    initial begin
        // Expected combo/multiplier after the edge that samples each row.
        tbl[0]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 0, 1};
        tbl[1]  = '{1'b0, 1'b1, 4'b0001, 4'b0000, 0, 1};
        tbl[2]  = '{1'b0, 1'b1, 4'b1000, 4'b0000, 1, 1};
        tbl[3]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2, 1};
        tbl[4]  = '{1'b0, 1'b1, 4'b0101, 4'b0100, 2, 1};
        tbl[5]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 3, 1};
        tbl[6]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 0, 1};
        tbl[7]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 0, 1};
        tbl[8]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 0, 1};
        tbl[9]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1, 1};
        tbl[10] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2, 1};
        tbl[11] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 3, 1};
        tbl[12] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4, 1};
        tbl[13] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4, 1};
        tbl[14] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 5, 1};
        tbl[15] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 6, 1};
        tbl[16] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 7, 1};
        tbl[17] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 8, 2};
        tbl[18] = '{1'b0, 1'b1, 4'b0000, 4'b0010, 8, 2};
        tbl[19] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 0, 1};

        // Reset values.
        resetbtn_n = 1'b0;
        drive(0, 0, 4'b0000, 4'b0000);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_score_bcd", 32'(score_bcd), 32'd0);
        check("rst_combo", 32'(combo), 32'd0);
        check("rst_mult", 32'(multiplier), 32'd1);
        check("rst_busy", 32'(bcd_busy), 32'd0);
        check("rst_high", 32'(high_bcd), 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        @(negedge clk);
        resetbtn_n = 1'b1;

        // Table vectors.
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].start, tbl[i].act, tbl[i].hit, tbl[i].miss);
            edge_only();
            check($sformatf("vec%0d_combo", i), 32'(combo), 32'(tbl[i].exp_combo));
            check($sformatf("vec%0d_mult", i), 32'(multiplier), 32'(tbl[i].exp_mult));
        end
        drive(0, 1, 4'b0000, 4'b0000);
        settle_check();
        check("vec_score_bcd", 32'(score_bcd), 32'h0110);

        // Single hit: score_bcd shows 0010 within 17 cycles of the sampling edge.
        drive(1, 1, 4'b0000, 4'b0000);
        tick();
        idle_ticks(20);
        check("start_clear_bcd", 32'(score_bcd), 32'h0000);
        drive(0, 1, 4'b0001, 4'b0000);
        tick();
        drive(0, 1, 4'b0000, 4'b0000);
        seen = 1'b0;
        lat  = 99;
        for (int c = 1; c <= 20 && !seen; c++) begin
            tick();
            if (score_bcd == 16'h0010) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check("hit1_bcd_seen", 32'(seen), 32'd1);
        check("hit1_latency_le17", 32'(lat <= 17), 32'd1);
        check("hit1_combo", 32'(combo), 32'd1);

        // Nine hits: multiplier steps to 2 after the eighth.
        drive(1, 1, 4'b0000, 4'b0000);
        tick();
        idle_ticks(20);
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 4'b0001, 4'b0000);
            tick();
        end
        check("hit8_combo", 32'(combo), 32'd8);
        check("hit8_mult", 32'(multiplier), 32'd2);
        drive(0, 1, 4'b0000, 4'b0000);
        tick();
        check("hit9_combo", 32'(combo), 32'd9);
        check("hit9_mult", 32'(multiplier), 32'd2);
        settle_check();
        check("hit9_bcd", 32'(score_bcd), 32'h0100);

        // Two lanes in one cycle are serviced over two cycles.
        drive(1, 1, 4'b0000, 4'b0000);
        tick();
        idle_ticks(20);
        drive(0, 1, 4'b1001, 4'b0000);
        tick();
        check("dual_combo0", 32'(combo), 32'd0);
        drive(0, 1, 4'b0000, 4'b0000);
        tick();
        check("dual_combo1", 32'(combo), 32'd1);
        tick();
        check("dual_combo2", 32'(combo), 32'd2);
        settle_check();
        check("dual_bcd", 32'(score_bcd), 32'h0020);

        // Combo 5, a miss, then hit+miss on the same lane.
        drive(1, 1, 4'b0000, 4'b0000);
        tick();
        idle_ticks(20);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 4'b0010, 4'b0000);
            tick();
        end
        drive(0, 1, 4'b0000, 4'b0000);
        tick();
        check("c5_combo", 32'(combo), 32'd5);
        drive(0, 1, 4'b0000, 4'b0100);
        tick();
        drive(0, 1, 4'b0000, 4'b0000);
        tick();
        check("miss_combo", 32'(combo), 32'd0);
        check("miss_mult", 32'(multiplier), 32'd1);
        settle_check();
        check("miss_bcd", 32'(score_bcd), 32'h0050);
        drive(0, 1, 4'b1000, 4'b1000);
        tick();
        drive(0, 1, 4'b0000, 4'b0000);
        tick();
        check("hitmiss_combo", 32'(combo), 32'd0);
        settle_check();
        check("hitmiss_bcd", 32'(score_bcd), 32'h0050);

        // Saturation: score stops at 9999, combo at 255, no wrap.
        drive(1, 1, 4'b0000, 4'b0000);
        tick();
        idle_ticks(20);
        mono_ok  = 1'b1;
        prev_val = 0;
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 4'b1111, 4'b0000);
            tick();
            if (bcd_to_int(score_bcd) < prev_val) mono_ok = 1'b0;
            prev_val = bcd_to_int(score_bcd);
        end
        idle_ticks(4);
        check("sat_combo", 32'(combo), 32'd255);
        check("sat_mult", 32'(multiplier), 32'd4);
        settle_check();
        check("sat_bcd", 32'(score_bcd), 32'h9999);
        check("sat_no_wrap", 32'(mono_ok), 32'd1);

        // Leaving PLAY drops pending events; values hold.
        drive(0, 1, 4'b0001, 4'b0000);
        tick();
        drive(0, 0, 4'b0000, 4'b0000);
        tick();
        check("leave_state", 32'(dbg_state_o), 32'd0);
        idle_ticks(3);
        check("leave_combo_held", 32'(combo), 32'd255);
        settle_check();
        drive(1, 1, 4'b0000, 4'b0000);
        tick();
        settle_check();
`ifdef SCORE_HIGH_EN
        check("high_kept", 32'(high_bcd), 32'h9999);
`else
        check("high_tied", 32'(high_bcd), 32'h0000);
`endif

        // Reset during a conversion.
        drive(0, 1, 4'b0001, 4'b0000);
        tick();
        drive(0, 1, 4'b0000, 4'b0000);
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            tick();
            if (bcd_busy) seen = 1'b1;
        end
        check("busy_seen", 32'(seen), 32'd1);
        resetbtn_n = 1'b0;
        #1;
        check("mid_rst_bcd", 32'(score_bcd), 32'd0);
        check("mid_rst_busy", 32'(bcd_busy), 32'd0);
        check("mid_rst_combo", 32'(combo), 32'd0);
        check("mid_rst_mult", 32'(multiplier), 32'd1);
        check("mid_rst_high", 32'(high_bcd), 32'd0);
        check("mid_rst_state", 32'(dbg_state_o), 32'd0);
        model_reset();
        @(negedge clk);
        resetbtn_n = 1'b1;

        // Randomized rounds against the model.
        drive(1, 1, 4'b0000, 4'b0000);
        tick();
        off_cnt = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 150; c++) begin
                rh = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                rm = ($urandom_range(0, 5) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
                if (off_cnt > 0) begin
                    off_cnt--;
                    if (off_cnt == 0) drive(1, 1, 4'b0000, 4'b0000);
                    else              drive(0, 0, rh, rm);
                end else if ($urandom_range(0, 59) == 0) begin
                    off_cnt = 3;
                    drive(0, 0, rh, rm);
                end else begin
                    drive(0, 1, rh, rm);
                end
                tick();
            end
            off_cnt = 0;
            if (!m_play) begin
                drive(1, 1, 4'b0000, 4'b0000);
                tick();
            end
            drive(0, 1, 4'b0000, 4'b0000);
            settle_check();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
